// File: rtl/spi_scheduler_pkg.sv
// Shared types and constants for the SPI transaction scheduler.
//   state_t    : scheduler FSM states
//   owner_t    : who issued the transaction in flight (CPU or status poll)
//   DEF_*      : default datagram / chip-select widths and poll datagram
//   ABORT_RESP : response handed to the CPU when a transaction is aborted
package spi_sched_pkg;

    localparam int DEF_SIZE     = 40;
    localparam int DEF_CS_WIDTH = 4;

    // Driver status read, sent on every autonomous poll
    localparam logic [DEF_SIZE-1:0] DEF_POLL_WORD = 40'h6F_0000_0000;
    localparam logic [DEF_SIZE-1:0] ABORT_RESP    = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_XFER,
        ST_DONE,
        ST_ABORT
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_POLL
    } owner_t;

endpackage

// File: rtl/spi_scheduler_if.sv
// Bundle of every scheduler signal except clock and reset.
//   CPU side : poll_en_i, req_i/req_data_i/req_cs_i/req_ready_o,
//              resp_valid_o/resp_data_o, rd_idx_i/rd_data_o, fault_o, timeout_o
//   SPI side : spi_data_o, spi_cs_o, spi_send_o, spi_rst_o, spi_ready_i, spi_data_i
// slave modport is the scheduler view; master is the surrounding system.
interface spi_scheduler_if
    import spi_sched_pkg::*;
#(
    parameter int SIZE     = DEF_SIZE,
    parameter int CS_WIDTH = DEF_CS_WIDTH,
    parameter int NUM_CS   = 12
);
    logic                poll_en_i;
    logic                req_i;
    logic [SIZE-1:0]     req_data_i;
    logic [CS_WIDTH-1:0] req_cs_i;
    logic                req_ready_o;
    logic                resp_valid_o;
    logic [SIZE-1:0]     resp_data_o;
    logic [CS_WIDTH-1:0] rd_idx_i;
    logic [SIZE-1:0]     rd_data_o;
    logic [NUM_CS-1:0]   fault_o;
    logic                timeout_o;
    logic [SIZE-1:0]     spi_data_o;
    logic [CS_WIDTH-1:0] spi_cs_o;
    logic                spi_send_o;
    logic                spi_rst_o;
    logic                spi_ready_i;
    logic [SIZE-1:0]     spi_data_i;

    modport slave (
        input  poll_en_i, req_i, req_data_i, req_cs_i, rd_idx_i, spi_ready_i, spi_data_i,
        output req_ready_o, resp_valid_o, resp_data_o, rd_data_o, fault_o, timeout_o,
               spi_data_o, spi_cs_o, spi_send_o, spi_rst_o
    );

    modport master (
        output poll_en_i, req_i, req_data_i, req_cs_i, rd_idx_i, spi_ready_i, spi_data_i,
        input  req_ready_o, resp_valid_o, resp_data_o, rd_data_o, fault_o, timeout_o,
               spi_data_o, spi_cs_o, spi_send_o, spi_rst_o
    );

endinterface

// File: rtl/spi_scheduler_poll_timer.sv
// Poll tick generator: free-running divider 0..POLL_DIV-1 with a saturating
// pending flag. Ports: clk_i, rst_i (sync, active-high), en_i (counter runs,
// low holds counter at 0 and drops pending), clr_i (pending consumed),
// pending_o (a poll is owed).
module poll_timer #(
    parameter int POLL_DIV = 25000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic pending_o
);
    localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(POLL_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_pending;
    logic          w_tick;

    assign w_tick    = (r_cnt == C_LAST);
    assign pending_o = r_pending;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            // A tick landing on the same cycle as a consume owes a fresh poll
            if (w_tick)
                r_pending <= 1'b1;
            else if (clr_i)
                r_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_scheduler.sv
// Shares one SPI master between CPU transactions and a round-robin status
// poll of NUM_CS stepper drivers. CPU requests have strict priority; a poll
// tick that loses arbitration stays pending. Poll responses fill a status
// buffer and a per-driver fault vector; a stuck phase is aborted after
// TIMEOUT cycles, resetting the SPI master.
// Ports: clk_i, rst_i (sync, active-high), bus (spi_scheduler_if.slave:
// CPU request/response, status buffer read, fault/timeout flags, SPI master
// control and return data).
module spi_scheduler
    import spi_sched_pkg::*;
#(
    parameter int              SIZE       = DEF_SIZE,
    parameter int              NUM_CS     = 12,
    parameter int              CS_WIDTH   = DEF_CS_WIDTH,
    parameter int              POLL_DIV   = 25000,
    parameter logic [SIZE-1:0] POLL_WORD  = DEF_POLL_WORD,
    parameter int              TIMEOUT    = 4096,
    parameter logic [7:0]      FAULT_MASK = 8'h03
) (
    input  logic           clk_i,
    input  logic           rst_i,
    spi_scheduler_if.slave bus
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]       T_LAST    = TW'(TIMEOUT - 1);
    localparam logic [CS_WIDTH-1:0] PTR_LAST  = CS_WIDTH'(NUM_CS - 1);
    localparam logic [CS_WIDTH:0]   IDX_LIMIT = (CS_WIDTH + 1)'(NUM_CS);

    state_t              r_state, w_next;
    owner_t              r_owner;
    logic [TW-1:0]       r_tcnt;
    logic [SIZE-1:0]     r_spi_data, r_resp_data, r_rd_data;
    logic [CS_WIDTH-1:0] r_spi_cs, r_ptr;
    logic                r_resp_valid, r_timeout;
    logic [NUM_CS-1:0]   r_fault;
    logic [SIZE-1:0]     r_buf [NUM_CS];

    logic                w_take_cpu, w_take_poll, w_pending, w_phase_expired;
    logic                w_buf_we, w_fault_bit, w_idx_ok;
    logic [CS_WIDTH-1:0] w_ptr_next;

    poll_timer #(.POLL_DIV(POLL_DIV)) u_poll_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (bus.poll_en_i),
        .clr_i     (w_take_poll),
        .pending_o (w_pending)
    );

    assign bus.req_ready_o  = (r_state == ST_IDLE);
    assign bus.spi_send_o   = (r_state == ST_ACCEPT);
    assign bus.spi_rst_o    = rst_i || (r_state == ST_ABORT);
    assign bus.resp_valid_o = r_resp_valid;
    assign bus.resp_data_o  = r_resp_data;
    assign bus.rd_data_o    = r_rd_data;
    assign bus.fault_o      = r_fault;
    assign bus.timeout_o    = r_timeout;
    assign bus.spi_data_o   = r_spi_data;
    assign bus.spi_cs_o     = r_spi_cs;

    assign w_buf_we    = (r_state == ST_DONE) && (r_owner == OWN_POLL);
    assign w_ptr_next  = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
    assign w_fault_bit = |(bus.spi_data_i[SIZE-1 -: 8] & FAULT_MASK);
    assign w_idx_ok    = ({1'b0, bus.rd_idx_i} < IDX_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        w_take_cpu      = 1'b0;
        w_take_poll     = 1'b0;
        w_phase_expired = (r_tcnt == T_LAST);
        case (r_state)
            ST_IDLE: begin
                if (bus.req_i) begin
                    w_take_cpu = 1'b1;
                    w_next     = ST_ACCEPT;
                end else if (w_pending) begin
                    w_take_poll = 1'b1;
                    w_next      = ST_ACCEPT;
                end
            end
            // ready dropping means the master latched the datagram and started
            ST_ACCEPT: begin
                if (!bus.spi_ready_i)
                    w_next = ST_XFER;
                else if (w_phase_expired)
                    w_next = ST_ABORT;
            end
            ST_XFER: begin
                if (bus.spi_ready_i)
                    w_next = ST_DONE;
                else if (w_phase_expired)
                    w_next = ST_ABORT;
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_ABORT: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Per-phase watchdog, restarted on every state change
    always_ff @(posedge clk_i) begin
        if (rst_i || (w_next != r_state))
            r_tcnt <= '0;
        else if ((r_state == ST_ACCEPT) || (r_state == ST_XFER))
            r_tcnt <= r_tcnt + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner      <= OWN_CPU;
            r_spi_data   <= '0;
            r_spi_cs     <= '0;
            r_ptr        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_timeout    <= 1'b0;
            r_fault      <= '0;
            r_rd_data    <= '0;
            for (int k = 0; k < NUM_CS; k++)
                r_buf[k] <= '0;
        end else begin
            r_resp_valid <= 1'b0;

            if (w_take_cpu) begin
                r_spi_data <= bus.req_data_i;
                r_spi_cs   <= bus.req_cs_i;
                r_owner    <= OWN_CPU;
            end else if (w_take_poll) begin
                r_spi_data <= POLL_WORD;
                r_spi_cs   <= r_ptr;
                r_owner    <= OWN_POLL;
            end

            case (r_state)
                ST_DONE: begin
                    if (r_owner == OWN_CPU) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= bus.spi_data_i;
                    end else begin
                        r_buf[r_ptr]   <= bus.spi_data_i;
                        r_fault[r_ptr] <= w_fault_bit;
                        r_ptr          <= w_ptr_next;
                    end
                end
                // Aborted poll skips its driver so one dead chip cannot stall the sweep
                ST_ABORT: begin
                    r_timeout <= 1'b1;
                    if (r_owner == OWN_CPU) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= ABORT_RESP[SIZE-1:0];
                    end else begin
                        r_ptr <= w_ptr_next;
                    end
                end
                default: ;
            endcase

            // Forward a same-cycle buffer write so the reader never sees stale data
            if (!w_idx_ok)
                r_rd_data <= '0;
            else if (w_buf_we && (bus.rd_idx_i == r_ptr))
                r_rd_data <= bus.spi_data_i;
            else
                r_rd_data <= r_buf[bus.rd_idx_i];
        end
    end

endmodule

// File: tb/tb_spi_scheduler.sv
module tb_spi_scheduler;
    import spi_sched_pkg::*;

    localparam int SIZE     = 40;
    localparam int NUM_CS   = 12;
    localparam int CS_WIDTH = 4;
    localparam logic [39:0] PW = 40'h6F_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_scheduler_if #(.SIZE(SIZE), .CS_WIDTH(CS_WIDTH), .NUM_CS(NUM_CS)) bus ();

    spi_scheduler #(
        .SIZE(SIZE), .NUM_CS(NUM_CS), .CS_WIDTH(CS_WIDTH), .POLL_DIV(16),
        .POLL_WORD(PW), .TIMEOUT(64), .FAULT_MASK(8'h03)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic [39:0] exp_q[$];
    int          resp_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.resp_valid_o === 1'b1) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got %0h expected none", bus.resp_data_o);
                end else begin
                    check("resp_data", bus.resp_data_o, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- SPI master model ----------------
    bit          stall    = 1'b0;
    int          xfer_len = 3;
    int          mode     = 0;
    bit          fault5   = 1'b0;
    logic [39:0] cpu_resp = '0;
    bit          busy     = 1'b0;
    int          cnt      = 0;
    logic [39:0] lat_data;
    logic [3:0]  lat_cs;
    logic [4:0]  start_log[$];
    logic [3:0]  poll_q[$];
    time         raise_time = 0;
    time         start_time = 0;

    function automatic logic [39:0] resp_for(input logic [39:0] d, input logic [3:0] cs);
        if (d != PW)
            return cpu_resp;
        if (mode == 0)
            return {4'h0, cs, 32'hCAFE_0000 + {28'h0, cs}};
        return {((cs == 4'd5) && fault5) ? 8'h02 : 8'h00, 32'hBEEF_0000 + {28'h0, cs}};
    endfunction

    initial begin
        bus.spi_ready_i = 1'b1;
        bus.spi_data_i  = '0;
        forever begin
            @(negedge clk);
            if (bus.spi_rst_o) begin
                busy            = 1'b0;
                bus.spi_ready_i = 1'b1;
            end else if (busy) begin
                if (cnt == 0) begin
                    bus.spi_data_i  = resp_for(lat_data, lat_cs);
                    bus.spi_ready_i = 1'b1;
                    busy            = 1'b0;
                    raise_time      = $time;
                end else begin
                    cnt--;
                end
            end else if (bus.spi_send_o && !stall) begin
                busy            = 1'b1;
                bus.spi_ready_i = 1'b0;
                cnt             = xfer_len;
                lat_data        = bus.spi_data_o;
                lat_cs          = bus.spi_cs_o;
                start_time      = $time;
                start_log.push_back({bus.spi_data_o == PW, bus.spi_cs_o});
                if (bus.spi_data_o == PW)
                    poll_q.push_back(bus.spi_cs_o);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [39:0] d, input logic [3:0] cs, input logic [39:0] r, input bit push);
        bus.req_i      = 1'b1;
        bus.req_data_i = d;
        bus.req_cs_i   = cs;
        cpu_resp       = r;
        if (push)
            exp_q.push_back(r);
        @(negedge clk);
        bus.req_i = 1'b0;
    endtask

    task automatic wait_resp_pulse(input string name);
        int i = 0;
        while (!bus.resp_valid_o && i < 200) begin
            @(negedge clk);
            i++;
        end
        check(name, bus.resp_valid_o, 1'b1);
    endtask

    task automatic wait_polls(input int n, input int budget, input string name);
        int i = 0;
        while (poll_q.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, poll_q.size() >= n, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},  bus.req_ready_o,  1'b1);
        check({tag, "_resp_valid"}, bus.resp_valid_o, 1'b0);
        check({tag, "_resp_data"},  bus.resp_data_o,  40'h0);
        check({tag, "_rd_data"},    bus.rd_data_o,    40'h0);
        check({tag, "_fault"},      bus.fault_o,      12'h0);
        check({tag, "_timeout"},    bus.timeout_o,    1'b0);
        check({tag, "_spi_data"},   bus.spi_data_o,   40'h0);
        check({tag, "_spi_cs"},     bus.spi_cs_o,     4'h0);
        check({tag, "_spi_send"},   bus.spi_send_o,   1'b0);
        check({tag, "_spi_rst"},    bus.spi_rst_o,    1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   ready_hi;
        int   sends;
        int   i;
        time  t_resp;

        bus.poll_en_i  = 1'b0;
        bus.req_i      = 1'b0;
        bus.req_data_i = '0;
        bus.req_cs_i   = '0;
        bus.rd_idx_i   = '0;

        repeat (3) @(negedge clk);
        check("spi_rst_during_reset", bus.spi_rst_o, 1'b1);
        rst = 1'b0;
        #1;
        check_reset_values("por");

        // CPU request to cs 3
        @(negedge clk);
        xfer_len = 5;
        issue(40'h80_0000_00AA, 4'd3, 40'h12_3456_789A, 1'b1);
        check("cpu_cs_after_accept", bus.spi_cs_o, 4'd3);
        check("cpu_send_after_accept", bus.spi_send_o, 1'b1);
        check("cpu_data_after_accept", bus.spi_data_o, 40'h80_0000_00AA);
        ready_hi = 0;
        i = 0;
        while (!bus.resp_valid_o && i < 200) begin
            if (bus.req_ready_o)
                ready_hi++;
            @(negedge clk);
            i++;
        end
        check("cpu_resp_arrived", bus.resp_valid_o, 1'b1);
        check("cpu_ready_low_in_flight", ready_hi, 0);
        check("cpu_resp_latency", ($time - raise_time) / 10, 2);

        // Out-of-range chip select is still sent
        @(negedge clk);
        issue(40'h80_0000_0001, 4'd14, 40'h0E_0000_00EE, 1'b1);
        check("oor_cs_sent", bus.spi_cs_o, 4'd14);
        wait_resp_pulse("oor_resp_arrived");

        // Round-robin polling
        @(negedge clk);
        poll_q.delete();
        xfer_len = 2;
        mode = 0;
        bus.poll_en_i = 1'b1;
        wait_polls(13, 400, "poll13_started");
        bus.poll_en_i = 1'b0;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 13; k++)
            check("poll_order", (poll_q.size() > k) ? {60'h0, poll_q[k]} : 64'hx, k % 12);
        for (int k = 0; k < 12; k++) begin
            bus.rd_idx_i = 4'(k);
            @(negedge clk);
            check("buf_entry", bus.rd_data_o, {8'(k), 32'hCAFE_0000 + 32'(k)});
        end
        bus.rd_idx_i = 4'd13;
        @(negedge clk);
        check("buf_oor_index", bus.rd_data_o, 40'h0);
        check("fault_after_sweep", bus.fault_o, 12'hEEE);

        // Fault on cs 5 only, then cleared
        mode = 1;
        fault5 = 1'b1;
        poll_q.delete();
        bus.poll_en_i = 1'b1;
        wait_polls(12, 400, "fault_sweep_started");
        bus.poll_en_i = 1'b0;
        repeat (20) @(negedge clk);
        check("fault_cs5_set", bus.fault_o, 12'h020);
        fault5 = 1'b0;
        poll_q.delete();
        bus.poll_en_i = 1'b1;
        wait_polls(12, 400, "clear_sweep_started");
        bus.poll_en_i = 1'b0;
        repeat (20) @(negedge clk);
        check("fault_cs5_cleared", bus.fault_o, 12'h000);

        // CPU request colliding with a poll tick
        @(negedge clk);
        start_log.delete();
        mode = 0;
        xfer_len = 25;
        bus.poll_en_i = 1'b1;
        repeat (15) @(negedge clk);
        issue(40'h80_0000_0055, 4'd9, 40'h55_AAAA_0001, 1'b1);
        wait_resp_pulse("collide_cpu_resp");
        t_resp = $time;
        i = 0;
        while (start_log.size() < 2 && i < 10) begin
            @(negedge clk);
            i++;
        end
        bus.poll_en_i = 1'b0;
        repeat (60) @(negedge clk);
        check("collide_two_xfers", start_log.size(), 2);
        check("collide_cpu_first", (start_log.size() > 0) ? {59'h0, start_log[0]} : 64'hx, {1'b0, 4'd9});
        check("collide_poll_second", (start_log.size() > 1) ? {63'h0, start_log[1][4]} : 64'hx, 1'b1);
        check("collide_poll_follows", (start_time - t_resp) / 10, 1);

        // Timeout: master never starts
        @(negedge clk);
        stall = 1'b1;
        issue(40'h01_0000_0000, 4'd2, 40'hFF_FFFF_FFFF, 1'b1);
        sends = 0;
        i = 0;
        while (!bus.spi_rst_o && i < 200) begin
            if (bus.spi_send_o)
                sends++;
            @(negedge clk);
            i++;
        end
        check("abort_spi_rst", bus.spi_rst_o, 1'b1);
        check("abort_after_cycles", sends, 64);
        @(negedge clk);
        check("abort_rst_one_cycle", bus.spi_rst_o, 1'b0);
        check("abort_timeout_flag", bus.timeout_o, 1'b1);
        check("abort_resp_valid", bus.resp_valid_o, 1'b1);
        stall = 1'b0;

        // Reset in the middle of a transfer
        @(negedge clk);
        xfer_len = 30;
        bus.rd_idx_i = 4'd0;
        issue(40'h80_0000_0077, 4'd6, 40'h66_0000_0006, 1'b0);
        repeat (5) @(negedge clk);
        check("xfer_send_dropped", bus.spi_send_o, 1'b0);
        #2 rst = 1'b1;
        #1 check("mid_reset_spi_rst", bus.spi_rst_o, 1'b1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check_reset_values("mid");
        @(negedge clk);
        check("buffer_cleared", bus.rd_data_o, 40'h0);
        xfer_len = 3;
        issue(40'h80_0000_0007, 4'd7, 40'h77_0000_0007, 1'b1);
        check("post_reset_cs", bus.spi_cs_o, 4'd7);
        wait_resp_pulse("post_reset_resp");

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
